// File: rtl/uart_axis_rx_if.sv
// AXI-Stream byte channel carrying received UART characters downstream.
interface uart_axis_rx_if #(
    parameter int unsigned NBITS = 8
);
    logic [NBITS-1:0] tdata;
    logic             tvalid;
    logic             tlast;
    logic             tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/uart_axis_rx.sv
// 8N1 UART receiver with oversampled majority-vote bit decisions and an AXI-Stream
// master output; an idle gap on the line closes the current packet with tlast.
module uart_axis_rx #(
    parameter int unsigned CLKRATE_MHZ   = 200,
    parameter int unsigned BAUD_RATE_BPS = 9600,
    parameter int unsigned OVERSAMPLE    = 16,
    parameter int unsigned NBITS         = 8,
    parameter int unsigned IDLE_BITS     = 20
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           rx,
    uart_axis_rx_if.master m_axis,
    output logic           frame_err,
    output logic           overrun,
    output logic           busy
);
    localparam int unsigned DIV        = (CLKRATE_MHZ * 1000000) / (BAUD_RATE_BPS * OVERSAMPLE);
    localparam int unsigned DIVW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned H          = OVERSAMPLE / 2;
    localparam int unsigned SCW        = $clog2(OVERSAMPLE);
    localparam int unsigned BCW        = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int unsigned IDLE_TICKS = IDLE_BITS * OVERSAMPLE;
    localparam int unsigned ITW        = $clog2(IDLE_TICKS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state_q, state_d;
    logic             rx_meta, rxs;
    logic [DIVW-1:0]  div_cnt;
    logic             tick;
    logic [SCW-1:0]   sc;
    logic [BCW-1:0]   bit_cnt;
    logic             samp_a, samp_b, maj, at_dec;
    logic [NBITS-1:0] shreg;
    logic             start_det, byte_done, ferr_d;
    logic [NBITS-1:0] pend_data;
    logic             pend_valid, pend_last;
    logic [ITW-1:0]   idle_cnt;
    logic             idle_hit, out_free, move;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            div_cnt <= '0;
        else if (tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    assign tick   = (div_cnt == DIVW'(DIV - 1));
    // Third vote is the live sample taken at the decision point itself.
    assign maj    = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);
    assign at_dec = tick && (sc == SCW'(H + 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        start_det = 1'b0;
        byte_done = 1'b0;
        ferr_d    = 1'b0;
        if (tick) begin
            unique case (state_q)
                S_IDLE: if (!rxs) begin
                    state_d   = S_START;
                    start_det = 1'b1;
                end
                S_START: if (at_dec) state_d = maj ? S_IDLE : S_DATA;
                S_DATA:  if (at_dec && (bit_cnt == BCW'(NBITS - 1))) state_d = S_STOP;
                S_STOP: if (at_dec) begin
                    if (maj) begin
                        byte_done = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
                S_BREAK: if (rxs) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sc      <= '0;
            bit_cnt <= '0;
            samp_a  <= 1'b1;
            samp_b  <= 1'b1;
            shreg   <= '0;
        end else if (start_det) begin
            sc      <= '0;
            bit_cnt <= '0;
        end else if (tick && (state_q == S_START || state_q == S_DATA || state_q == S_STOP)) begin
            sc <= (sc == SCW'(OVERSAMPLE - 1)) ? '0 : sc + 1'b1;
            if (sc == SCW'(H - 1)) samp_a <= rxs;
            if (sc == SCW'(H))     samp_b <= rxs;
            if (at_dec && state_q == S_DATA) begin
                shreg   <= NBITS'({maj, shreg} >> 1);
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            idle_cnt <= '0;
        else if (start_det || byte_done)
            idle_cnt <= '0;
        else if (tick && state_q == S_IDLE && pend_valid && !pend_last &&
                 idle_cnt != ITW'(IDLE_TICKS))
            idle_cnt <= idle_cnt + 1'b1;
    end

    assign idle_hit = pend_valid && !pend_last && (idle_cnt == ITW'(IDLE_TICKS));
    assign out_free = !m_axis.tvalid || m_axis.tready;
    // A non-final byte only leaves pend when its successor arrives, so tlast stays exact.
    assign move     = pend_valid && out_free && (pend_last || byte_done);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_axis.tdata  <= '0;
            m_axis.tvalid <= 1'b0;
            m_axis.tlast  <= 1'b0;
            pend_data     <= '0;
            pend_valid    <= 1'b0;
            pend_last     <= 1'b0;
            frame_err     <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            frame_err <= ferr_d;
            overrun   <= 1'b0;
            if (move) begin
                m_axis.tdata  <= pend_data;
                m_axis.tlast  <= pend_last;
                m_axis.tvalid <= 1'b1;
            end else if (m_axis.tvalid && m_axis.tready) begin
                m_axis.tvalid <= 1'b0;
            end
            if (byte_done) begin
                if (!pend_valid || move) begin
                    pend_data  <= shreg;
                    pend_valid <= 1'b1;
                    pend_last  <= 1'b0;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (move) begin
                pend_valid <= 1'b0;
                pend_last  <= 1'b0;
            end else if (idle_hit) begin
                pend_last <= 1'b1;
            end
        end
    end

    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_axis_rx.sv
// Randomised and directed bench for uart_axis_rx: expected beats come from the
// serial-level rule "tlast marks the last byte before a long idle gap".
module tb_uart_axis_rx;
    localparam int unsigned CLK_MHZ  = 1;
    localparam int unsigned BAUD     = 15625;
    localparam int unsigned OS       = 16;
    localparam int unsigned NB       = 8;
    localparam int unsigned IDLE_B   = 3;
    localparam int unsigned DIV      = (CLK_MHZ * 1000000) / (BAUD * OS);
    localparam int unsigned BIT      = DIV * OS;
    localparam int unsigned LONG_GAP = IDLE_B + 3;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } beat_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic rx   = 1'b1;
    logic frame_err, overrun, busy;
    logic ready_fix  = 1'b1;
    logic rand_ready = 1'b0;

    int checks = 0;
    int failures = 0;
    int ferr_seen = 0, ovr_seen = 0, beat_cnt = 0;
    int exp_ferr = 0, exp_ovr = 0;
    int b0, f0;
    logic [7:0] last_data;
    logic       last_last;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;
    beat_t      exp_q[$];
    beat_t      mon_e;
    logic [7:0] rd;
    logic       rlong;
    int unsigned rgap;

    uart_axis_rx_if #(.NBITS(NB)) m_axis ();

    uart_axis_rx #(
        .CLKRATE_MHZ  (CLK_MHZ),
        .BAUD_RATE_BPS(BAUD),
        .OVERSAMPLE   (OS),
        .NBITS        (NB),
        .IDLE_BITS    (IDLE_B)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rx       (rx),
        .m_axis   (m_axis),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold_line(input logic level, input int unsigned clocks);
        rx = level;
        wait_clks(clocks);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop, input int glitch_bit);
        hold_line(1'b0, BIT);
        for (int i = 0; i < 8; i++) begin
            if (i == glitch_bit) begin
                hold_line(data[i], BIT / 2 - 2);
                hold_line(~data[i], DIV);
                hold_line(data[i], BIT - (BIT / 2 - 2) - DIV);
            end else begin
                hold_line(data[i], BIT);
            end
        end
        hold_line(stop, BIT);
    endtask

    task automatic gap(input int unsigned bits);
        hold_line(1'b1, bits * BIT);
    endtask

    task automatic expect_beat(input logic [7:0] d, input logic l);
        beat_t b;
        b.d = d;
        b.l = l;
        exp_q.push_back(b);
    endtask

    task automatic drain(input string name);
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < 40 * BIT) begin
            wait_clks(1);
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        m_axis.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis.tready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_fix;
        end
    end

    always @(negedge clk) begin
        if (!rstn) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_tvalid", m_axis.tvalid, 1);
                chk("hold_tdata", m_axis.tdata, prev_data);
                chk("hold_tlast", m_axis.tlast, prev_last);
            end
            if (m_axis.tvalid && m_axis.tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=%0h/%0b required=no_beat",
                             m_axis.tdata, m_axis.tlast);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("beat_tdata", m_axis.tdata, mon_e.d);
                    chk("beat_tlast", m_axis.tlast, mon_e.l);
                end
                beat_cnt++;
                last_data = m_axis.tdata;
                last_last = m_axis.tlast;
            end
            if (frame_err) ferr_seen++;
            if (overrun)   ovr_seen++;
            prev_hold = m_axis.tvalid && !m_axis.tready;
            prev_data = m_axis.tdata;
            prev_last = m_axis.tlast;
        end
    end

    initial begin
        wait_clks(3);
        chk("rst_tvalid", m_axis.tvalid, 0);
        chk("rst_tdata", m_axis.tdata, 0);
        chk("rst_tlast", m_axis.tlast, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);
        rstn = 1'b1;
        gap(2);

        // T1: single byte, closed by the idle gap
        expect_beat(8'hA5, 1'b1);
        send_frame(8'hA5, 1'b1, -1);
        gap(1);
        chk("t1_no_early_beat", m_axis.tvalid, 0);
        gap(LONG_GAP);
        drain("t1_drain");
        chk("t1_tdata", last_data, 8'hA5);
        chk("t1_tlast", last_last, 1);

        // T2: back-to-back packet of three
        expect_beat(8'h01, 1'b0);
        expect_beat(8'h02, 1'b0);
        expect_beat(8'h03, 1'b1);
        send_frame(8'h01, 1'b1, -1);
        send_frame(8'h02, 1'b1, -1);
        send_frame(8'h03, 1'b1, -1);
        gap(LONG_GAP);
        drain("t2_drain");
        chk("t2_tdata", last_data, 8'h03);
        chk("t2_overrun", ovr_seen, exp_ovr);

        // T3: short low pulse is a false start
        b0 = beat_cnt;
        f0 = ferr_seen;
        hold_line(1'b0, 4 * DIV);
        chk("t3_busy_high", busy, 1);
        gap(2);
        chk("t3_busy_low", busy, 0);
        chk("t3_no_beat", beat_cnt, b0);
        chk("t3_no_ferr", ferr_seen, f0);

        // T4: bad stop bit, then a clean frame
        b0 = beat_cnt;
        send_frame(8'h55, 1'b0, -1);
        exp_ferr++;
        gap(2);
        chk("t4_frame_err", ferr_seen, exp_ferr);
        chk("t4_no_beat", beat_cnt, b0);
        chk("t4_busy_low", busy, 0);
        expect_beat(8'h3C, 1'b1);
        send_frame(8'h3C, 1'b1, -1);
        gap(LONG_GAP);
        drain("t4_drain");
        chk("t4_tdata", last_data, 8'h3C);

        // T5: stalled consumer, third byte overruns
        ready_fix = 1'b0;
        wait_clks(2);
        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h22, 1'b1, -1);
        send_frame(8'h33, 1'b1, -1);
        exp_ovr++;
        gap(LONG_GAP);
        chk("t5_overrun", ovr_seen, exp_ovr);
        chk("t5_tvalid", m_axis.tvalid, 1);
        chk("t5_tdata", m_axis.tdata, 8'h11);
        chk("t5_tlast", m_axis.tlast, 0);
        expect_beat(8'h11, 1'b0);
        expect_beat(8'h22, 1'b1);
        ready_fix = 1'b1;
        drain("t5_drain");
        chk("t5_last_tdata", last_data, 8'h22);

        // T6: glitch rejection, then reset mid-frame with a held output byte
        expect_beat(8'h00, 1'b1);
        send_frame(8'h00, 1'b1, 3);
        gap(LONG_GAP);
        drain("t6_drain_glitch");
        chk("t6_glitch_tdata", last_data, 8'h00);
        ready_fix = 1'b0;
        wait_clks(2);
        send_frame(8'h5A, 1'b1, -1);
        gap(LONG_GAP);
        chk("t6_held_tvalid", m_axis.tvalid, 1);
        chk("t6_held_tdata", m_axis.tdata, 8'h5A);
        hold_line(1'b0, BIT);
        hold_line(1'b1, BIT);
        hold_line(1'b0, BIT / 2);
        chk("t6_busy_mid", busy, 1);
        rstn = 1'b0;
        #1;
        chk("t6_rst_tvalid", m_axis.tvalid, 0);
        chk("t6_rst_tdata", m_axis.tdata, 0);
        chk("t6_rst_tlast", m_axis.tlast, 0);
        chk("t6_rst_busy", busy, 0);
        wait_clks(3);
        rx = 1'b1;
        rstn = 1'b1;
        ready_fix = 1'b1;
        gap(2);
        expect_beat(8'h7E, 1'b1);
        send_frame(8'h7E, 1'b1, -1);
        gap(LONG_GAP);
        drain("t6_drain_7e");
        chk("t6_tdata", last_data, 8'h7E);

        // Random bytes and gaps with a randomly stalling consumer
        rand_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rd    = 8'($urandom_range(0, 255));
            rlong = ($urandom_range(0, 2) == 0) || (i == 11);
            rgap  = rlong ? LONG_GAP + $urandom_range(0, 2) : $urandom_range(0, 1);
            expect_beat(rd, rlong);
            send_frame(rd, 1'b1, -1);
            gap(rgap);
        end
        drain("rand_drain");
        rand_ready = 1'b0;
        wait_clks(4);

        chk("final_frame_err", ferr_seen, exp_ferr);
        chk("final_overrun", ovr_seen, exp_ovr);
        chk("final_queue", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #600000;
        checks++;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
